uart_tx_sequencer: RTL and testbench
====================================

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency used for baud divisors.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 arst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 active  input  1  UART enable from control register.
REQ-005 frame_type  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-006 parity_type  input  2  00=none, 01=odd, 10=even, 11=none.
REQ-007 stop_type  input  1  0=one stop bit, 1=two stop bits.
REQ-008 baud_rate  input  4  baud table index.
REQ-009 tnsm  input  1  transmit request flag from control register.
REQ-010 tnsm_data  input  8  byte to transmit.
REQ-011 tnsm_clr  output  1  request-clear strobe to control register.
REQ-012 tx  output  1  serial line, idle high.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP, CLR.
REQ-015 IDLE: tx=1; when active=1 and tnsm=1, snapshot frame_type, parity_type, stop_type, baud divisor and tnsm_data, go to START the next cycle.
REQ-016 Snapshot is used for the whole frame; input changes (including active falling) mid-frame have no effect until return to IDLE.
REQ-017 Bit period = DIV[baud_rate] clocks, DIV = round(CLK_FREQ_HZ/baud), minimum 1; a down-counter reloads at each bit boundary.
REQ-018 Baud table 0..15: 300, 600, 1200, 1800, 2400, 4800, 7200, 9600, 14400, 19200, 38400, 57600, 115200, 230400, 460800, 921600.
REQ-019 START: tx=0 for one bit period, then DATA.
REQ-020 DATA: send snapshot bits LSB first, exactly N bits (N from frame_type), one bit period each; bits above N-1 are ignored.
REQ-021 After DATA go to PARITY if parity is odd/even, else STOP.
REQ-022 PARITY: even -> XOR of the N data bits; odd -> its inverse; one bit period.
REQ-023 STOP: tx=1 for one or two bit periods, then CLR.
REQ-024 CLR: tx=1, tnsm_clr=1; hold until tnsm sampled 0, then tnsm_clr=0 and IDLE the following cycle (covers a clear lost to a concurrent register write).
REQ-025 tnsm_clr is 0 in every state other than CLR.
REQ-026 First tx falling edge occurs exactly one cycle after the accept cycle; frame length = (1+N+P+S)*DIV clocks, P in {0,1}, S in {1,2}.
REQ-027 tx, tnsm_clr, busy are registered outputs (no combinational path from inputs).

Reset
REQ-028 On arst_n low, immediately: state=IDLE, tx=1, tnsm_clr=0, busy=0, counters and snapshot zero.
REQ-029 Reset mid-frame aborts the frame; tnsm is not cleared by this block, so the frame restarts after reset if tnsm is still 1.

Structure
REQ-030 Shared package uart_pkg holds the FSM state enum, frame/parity encodings, and the baud table with a divisor function of CLK_FREQ_HZ.
REQ-031 One sub-module uart_baud_gen (divisor counter producing bit-boundary tick, restart input) is natural; the FSM stays in uart_tx_sequencer.

Verification
REQ-032 8N1, baud 7 (DIV=5208), data 0x55, tnsm=1 -> tx: 0 for 5208 clocks, then 1,0,1,0,1,0,1,0 at 5208 clocks each, then 1 for 5208; tnsm_clr asserted at clock 52080 after the first tx low.
REQ-033 5 bits, odd parity, 2 stop, data 0xE3 -> data bits 1,1,0,0,0; parity 1; two stop bits; frame = 9*DIV clocks.
REQ-034 active=0, tnsm=1 -> tx stays 1, busy stays 0, tnsm_clr stays 0; raise active -> frame starts one cycle later.
REQ-035 In CLR, hold tnsm=1 for 10 cycles -> tnsm_clr held 10 cycles, no second frame; drop tnsm -> IDLE next cycle.
REQ-036 Change baud_rate, frame_type and tnsm_data mid-frame -> current frame bit-exact to the snapshot.
REQ-037 Assert arst_n=0 during DATA -> tx=1, busy=0 same cycle; release with tnsm=1 -> full new frame from START.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: FSM states, frame/parity encodings
// and the baud table with its divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_CLR
    } tx_state_t;

    localparam logic [1:0] FRAME_5 = 2'b00;
    localparam logic [1:0] FRAME_6 = 2'b01;
    localparam logic [1:0] FRAME_7 = 2'b10;
    localparam logic [1:0] FRAME_8 = 2'b11;

    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    localparam int DIV_W = 24;
    typedef logic [DIV_W-1:0] div_t;
    typedef div_t [15:0] div_table_t;

    localparam int unsigned BAUD_TABLE [16] = '{
        300, 600, 1200, 1800, 2400, 4800, 7200, 9600,
        14400, 19200, 38400, 57600, 115200, 230400, 460800, 921600
    };

    // Rounded clocks-per-bit, never below one clock.
    function automatic div_t baudDivisor(input longint unsigned clkHz, input int unsigned idx);
        longint unsigned baud;
        longint unsigned d;
        baud = longint'(BAUD_TABLE[idx]);
        d    = (clkHz + baud / 2) / baud;
        if (d < 1) d = 1;
        return div_t'(d);
    endfunction

    function automatic div_table_t buildDivTable(input longint unsigned clkHz);
        div_table_t t;
        for (int i = 0; i < 16; i++) t[i] = baudDivisor(clkHz, i);
        return t;
    endfunction

    function automatic logic [2:0] frameLastBit(input logic [1:0] frame);
        case (frame)
            FRAME_5: return 3'd4;
            FRAME_6: return 3'd5;
            FRAME_7: return 3'd6;
            FRAME_8: return 3'd7;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter: ticks on the last clock of each bit period and
// reloads from i_div; i_restart aligns a fresh period to the frame start.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic i_restart,
    input  div_t i_div,
    output logic o_tick
);

    div_t r_count;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_count <= '0;
        end else if (i_restart || r_count == '0) begin
            r_count <= i_div - div_t'(1);
        end else begin
            r_count <= r_count - div_t'(1);
        end
    end

    assign o_tick = (r_count == '0);

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: snapshots the frame configuration on accept and
// serialises start, data, optional parity and stop bits, then handshakes the clear.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       active,
    input  logic [1:0] frame_type,
    input  logic [1:0] parity_type,
    input  logic       stop_type,
    input  logic [3:0] baud_rate,
    input  logic       tnsm,
    input  logic [7:0] tnsm_data,
    output logic       tnsm_clr,
    output logic       tx,
    output logic       busy
);

    localparam div_table_t DIV_TABLE = buildDivTable(longint'(CLK_FREQ_HZ));

    tx_state_t  r_state;
    logic [7:0] r_data;
    logic [1:0] r_frame;
    logic [1:0] r_parity;
    logic       r_stop;
    div_t       r_div;
    logic [2:0] r_bitIdx;
    logic       r_stopCnt;
    logic       r_tx;
    logic       r_clr;
    logic       r_busy;

    logic       w_accept;
    logic       w_tick;
    div_t       w_div;
    logic [2:0] w_lastBit;
    logic [2:0] w_nextIdx;
    logic [7:0] w_dataMask;
    logic       w_parityBit;
    logic       w_parityOn;

    assign w_accept    = (r_state == ST_IDLE) && active && tnsm;
    assign w_div       = w_accept ? DIV_TABLE[baud_rate] : r_div;
    assign w_lastBit   = frameLastBit(r_frame);
    assign w_nextIdx   = r_bitIdx + 3'd1;
    assign w_dataMask  = 8'hFF >> (3'd7 - w_lastBit);
    assign w_parityBit = (^(r_data & w_dataMask)) ^ (r_parity == PARITY_ODD);
    assign w_parityOn  = (r_parity == PARITY_ODD) || (r_parity == PARITY_EVEN);

    uart_baud_gen u_baudGen (
        .i_clk     (clk),
        .i_arst_n  (arst_n),
        .i_restart (w_accept),
        .i_div     (w_div),
        .o_tick    (w_tick)
    );

    // Outputs are set on the transition into each state so tx is already valid
    // for the whole bit period that state represents.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state   <= ST_IDLE;
            r_data    <= '0;
            r_frame   <= '0;
            r_parity  <= '0;
            r_stop    <= 1'b0;
            r_div     <= '0;
            r_bitIdx  <= '0;
            r_stopCnt <= 1'b0;
            r_tx      <= 1'b1;
            r_clr     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data   <= tnsm_data;
                        r_frame  <= frame_type;
                        r_parity <= parity_type;
                        r_stop   <= stop_type;
                        r_div    <= DIV_TABLE[baud_rate];
                        r_state  <= ST_START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state  <= ST_DATA;
                        r_bitIdx <= '0;
                        r_tx     <= r_data[0];
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bitIdx == w_lastBit) begin
                            if (w_parityOn) begin
                                r_state <= ST_PARITY;
                                r_tx    <= w_parityBit;
                            end else begin
                                r_state   <= ST_STOP;
                                r_stopCnt <= 1'b0;
                                r_tx      <= 1'b1;
                            end
                        end else begin
                            r_bitIdx <= w_nextIdx;
                            r_tx     <= r_data[w_nextIdx];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state   <= ST_STOP;
                        r_stopCnt <= 1'b0;
                        r_tx      <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_stop && !r_stopCnt) begin
                            r_stopCnt <= 1'b1;
                        end else begin
                            r_state <= ST_CLR;
                            r_clr   <= 1'b1;
                        end
                    end
                end
                ST_CLR: begin
                    // Hold the strobe until the request flag is actually seen low.
                    if (!tnsm) begin
                        r_state <= ST_IDLE;
                        r_clr   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_clr   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign tnsm_clr = r_clr;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: stimulus queues hand-computed frames,
// a monitor checks every tx cycle of each frame against them.
module tb_uart_tx_sequencer;

    typedef struct {
        int          id;
        logic [15:0] bits;
        int          nBits;
        int          div;
        int          expStart;
    } exp_frame_t;

    logic       clk = 1'b0;
    logic       arst_n = 1'b1;
    logic       active = 1'b0;
    logic [1:0] frame_type = 2'b11;
    logic [1:0] parity_type = 2'b00;
    logic       stop_type = 1'b0;
    logic [3:0] baud_rate = 4'd15;
    logic       tnsm = 1'b0;
    logic [7:0] tnsm_data = 8'h00;
    logic       tnsm_clr;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cycleCnt = 0;
    exp_frame_t expQ [$];

    uart_tx_sequencer #(.CLK_FREQ_HZ(50_000_000)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .active      (active),
        .frame_type  (frame_type),
        .parity_type (parity_type),
        .stop_type   (stop_type),
        .baud_rate   (baud_rate),
        .tnsm        (tnsm),
        .tnsm_data   (tnsm_data),
        .tnsm_clr    (tnsm_clr),
        .tx          (tx),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Issue a request at a falling edge; accept lands on the next rising edge.
    task automatic applyStimulus(input int id, input logic [7:0] data, input logic [1:0] ft,
                                 input logic [1:0] pt, input logic st, input logic [3:0] baud,
                                 input logic [15:0] bits, input int nBits, input int div);
        exp_frame_t e;
        @(negedge clk);
        tnsm_data   = data;
        frame_type  = ft;
        parity_type = pt;
        stop_type   = st;
        baud_rate   = baud;
        active      = 1'b1;
        tnsm        = 1'b1;
        e.id = id; e.bits = bits; e.nBits = nBits; e.div = div; e.expStart = cycleCnt + 1;
        expQ.push_back(e);
    endtask

    task automatic waitClr(input int budget, input bit dropTnsm);
        int n = 0;
        while (tnsm_clr !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("clrSeen", tnsm_clr, 1);
        if (dropTnsm) begin
            tnsm = 1'b0;
            @(negedge clk);
            checkOutput("clrReleased", tnsm_clr, 0);
            checkOutput("idleAfterClr", busy, 0);
        end
    endtask

    initial begin : monitor
        exp_frame_t e;
        int waitCnt;
        int errCnt;
        forever begin
            wait (expQ.size() != 0);
            e = expQ.pop_front();
            waitCnt = 0;
            @(negedge clk);
            while (tx !== 1'b0 && waitCnt < 30) begin
                @(negedge clk);
                waitCnt++;
            end
            checkOutput($sformatf("frame%0d start", e.id), cycleCnt, e.expStart);
            if (tx === 1'b0) begin
                for (int i = 0; i < e.nBits; i++) begin
                    errCnt = 0;
                    for (int j = 0; j < e.div; j++) begin
                        if (i != 0 || j != 0) @(negedge clk);
                        if (tx !== e.bits[e.nBits-1-i] || busy !== 1'b1 || tnsm_clr !== 1'b0) errCnt++;
                    end
                    checkOutput($sformatf("frame%0d bit%0d badCycles", e.id, i), errCnt, 0);
                end
                @(negedge clk);
                checkOutput($sformatf("frame%0d clrAfterStop", e.id), tnsm_clr, 1);
            end
        end
    end

    initial begin : stimulus
        int errs;
        #1 arst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetTx", tx, 1);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetClr", tnsm_clr, 0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] 8N1 0x55 at 9600 baud");
        applyStimulus(1, 8'h55, 2'b11, 2'b00, 1'b0, 4'd7, 16'b0101010101, 10, 5208);
        waitClr(10 * 5208 + 50, 1'b1);

        $display("[TB] 5O2 0xE3 at 921600 baud");
        applyStimulus(2, 8'hE3, 2'b00, 2'b01, 1'b1, 4'd15, 16'b011000111, 9, 54);
        waitClr(9 * 54 + 50, 1'b1);

        $display("[TB] 7E1 0x3C at 460800 baud");
        applyStimulus(3, 8'h3C, 2'b10, 2'b10, 1'b0, 4'd14, 16'b0001111001, 10, 109);
        waitClr(10 * 109 + 50, 1'b1);

        $display("[TB] request held while inactive, then 6N1 0xA5 at 230400 baud");
        @(negedge clk);
        tnsm_data = 8'hA5; frame_type = 2'b01; parity_type = 2'b11; stop_type = 1'b0;
        baud_rate = 4'd13; active = 1'b0; tnsm = 1'b1;
        errs = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || tnsm_clr !== 1'b0) errs++;
        end
        checkOutput("inactiveIdleCycles", errs, 0);
        applyStimulus(4, 8'hA5, 2'b01, 2'b11, 1'b0, 4'd13, 16'b01010011, 8, 217);
        waitClr(8 * 217 + 50, 1'b1);

        $display("[TB] 8O2 0x81 with mid-frame input changes and held request");
        applyStimulus(5, 8'h81, 2'b11, 2'b01, 1'b1, 4'd15, 16'b010000001111, 12, 54);
        repeat (150) @(negedge clk);
        baud_rate = 4'd0; frame_type = 2'b00; parity_type = 2'b00; stop_type = 1'b0;
        tnsm_data = 8'hFF; active = 1'b0;
        waitClr(12 * 54 + 50, 1'b0);
        active = 1'b1;
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tnsm_clr !== 1'b1 || tx !== 1'b1 || busy !== 1'b1) errs++;
        end
        checkOutput("clrHoldCycles", errs, 0);
        tnsm = 1'b0;
        @(negedge clk);
        checkOutput("clrDropTnsmClr", tnsm_clr, 0);
        checkOutput("clrDropBusy", busy, 0);

        $display("[TB] reset during data bits, restart with request still set");
        @(negedge clk);
        tnsm_data = 8'h0F; frame_type = 2'b11; parity_type = 2'b00; stop_type = 1'b0;
        baud_rate = 4'd15; active = 1'b1; tnsm = 1'b1;
        repeat (54 * 3) @(negedge clk);
        arst_n = 1'b0;
        #1;
        checkOutput("abortTx", tx, 1);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortClr", tnsm_clr, 0);
        repeat (3) @(negedge clk);
        begin
            exp_frame_t e;
            e.id = 6; e.bits = 16'b0111100001; e.nBits = 10; e.div = 54; e.expStart = cycleCnt + 1;
            expQ.push_back(e);
        end
        arst_n = 1'b1;
        waitClr(10 * 54 + 80, 1'b1);

        repeat (5) @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
